// File: rtl/pipe_checker_pkg.sv
// Shared types and the reference model for the (a*b)&c pipeline result checker.
package pipe_checker_pkg;

  localparam int MAX_LATENCY = 8;
  localparam int MAX_WIDTH   = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Operands arrive zero-extended; the product is truncated to `width` bits before the AND.
  function automatic logic [MAX_WIDTH-1:0] expected_result(
    input logic [MAX_WIDTH-1:0] a,
    input logic [MAX_WIDTH-1:0] b,
    input logic [MAX_WIDTH-1:0] c,
    input int                   width
  );
    logic [MAX_WIDTH-1:0] prod;
    logic [MAX_WIDTH-1:0] mask;
    prod = a * b;
    mask = (width >= MAX_WIDTH) ? '1 : ((64'd1 << width) - 64'd1);
    return (prod & mask) & c;
  endfunction

endpackage

// File: rtl/pipe_checker_delay.sv
// LATENCY-deep shift register of {valid, data}; clear flushes the shifted entries
// while the head still loads, so an insert on the clear edge survives.
module pipe_checker_delay #(
  parameter int LATENCY = 3,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_v,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_v,
  output logic [DATA_W-1:0] o_data
);

  logic [LATENCY-1:0] r_v_p;
  logic [DATA_W-1:0]  r_data_p [LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v_p <= '0;
    end else begin
      r_v_p[0] <= i_v;
      for (int i = 1; i < LATENCY; i++) begin
        r_v_p[i] <= i_clr ? 1'b0 : r_v_p[i-1];
      end
    end
  end

  // Data carries no reset; the valid bits alone qualify it.
  always_ff @(posedge clk) begin
    r_data_p[0] <= i_data;
    for (int i = 1; i < LATENCY; i++) begin
      r_data_p[i] <= r_data_p[i-1];
    end
  end

  assign o_v    = r_v_p[LATENCY-1];
  assign o_data = r_data_p[LATENCY-1];

endmodule

// File: rtl/pipe_result_checker.sv
// Self-checking consumer for an (a*b)&c pipeline: delays the expected value by LATENCY
// and keeps pass/mismatch statistics. Define PIPE_CHECKER_CAPTURE_EN for first-mismatch capture.
module pipe_result_checker
  import pipe_checker_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int LATENCY   = 3,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [WIDTH-1:0]     c,
  input  logic [WIDTH-1:0]     p,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 err,
  output logic [CNT_WIDTH-1:0] checked_cnt,
  output logic [CNT_WIDTH-1:0] mismatch_cnt
`ifdef PIPE_CHECKER_CAPTURE_EN
  ,
  output logic [WIDTH-1:0]     first_exp,
  output logic [WIDTH-1:0]     first_got,
  output logic [CNT_WIDTH-1:0] first_idx
`endif
);

  localparam int DRAIN_W = $clog2(MAX_LATENCY + 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_clear;
  logic                 w_ins_v_p0;
  logic [WIDTH-1:0]     w_exp_p0;
  logic                 w_tail_v;
  logic [WIDTH-1:0]     w_tail_exp;
  logic [DRAIN_W-1:0]   r_drain_cnt;
  logic [CNT_WIDTH-1:0] r_checked_cnt;
  logic [CNT_WIDTH-1:0] r_mismatch_cnt;
  logic                 r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // start beats stop; start during DRAIN is not a listed transition and is ignored.
  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = RUN;
          w_clear     = 1'b1;
        end
      end
      RUN: begin
        if (start)     w_clear     = 1'b1;
        else if (stop) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (r_drain_cnt == DRAIN_W'(LATENCY - 1)) w_state_nxt = DONE;
      end
      DONE: begin
        if (start) begin
          w_state_nxt = RUN;
          w_clear     = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    w_ins_v_p0 = in_valid & ((r_state == RUN) | w_clear);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_drain_cnt <= '0;
    else if (r_state != DRAIN) r_drain_cnt <= '0;
    else                       r_drain_cnt <= r_drain_cnt + DRAIN_W'(1);
  end

  // ---- stage p0: expected value from the operands presented this cycle
  assign w_exp_p0 = WIDTH'(expected_result(MAX_WIDTH'(a), MAX_WIDTH'(b), MAX_WIDTH'(c), WIDTH));

  // ---- stages p1..pLATENCY: delay line aligning expectation with p
  pipe_checker_delay #(
    .LATENCY (LATENCY),
    .DATA_W  (WIDTH)
  ) u_delay (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_clear),
    .i_v    (w_ins_v_p0),
    .i_data (w_exp_p0),
    .o_v    (w_tail_v),
    .o_data (w_tail_exp)
  );

`ifdef PIPE_CHECKER_CAPTURE_EN
  logic [WIDTH-1:0]     r_first_exp;
  logic [WIDTH-1:0]     r_first_got;
  logic [CNT_WIDTH-1:0] r_first_idx;
`endif

  // ---- compare stage: saturating statistics; a clear on the start edge overrides any compare
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_checked_cnt  <= '0;
      r_mismatch_cnt <= '0;
      r_err          <= 1'b0;
`ifdef PIPE_CHECKER_CAPTURE_EN
      r_first_exp    <= '0;
      r_first_got    <= '0;
      r_first_idx    <= '0;
`endif
    end else if (w_clear) begin
      r_checked_cnt  <= '0;
      r_mismatch_cnt <= '0;
      r_err          <= 1'b0;
`ifdef PIPE_CHECKER_CAPTURE_EN
      r_first_exp    <= '0;
      r_first_got    <= '0;
      r_first_idx    <= '0;
`endif
    end else if (w_tail_v) begin
      if (r_checked_cnt != '1) r_checked_cnt <= r_checked_cnt + CNT_WIDTH'(1);
      if (p != w_tail_exp) begin
        if (r_mismatch_cnt != '1) r_mismatch_cnt <= r_mismatch_cnt + CNT_WIDTH'(1);
        r_err <= 1'b1;
`ifdef PIPE_CHECKER_CAPTURE_EN
        if (!r_err) begin
          r_first_exp <= w_tail_exp;
          r_first_got <= p;
          r_first_idx <= r_checked_cnt;
        end
`endif
      end
    end
  end

  assign busy         = (r_state == RUN) || (r_state == DRAIN);
  assign done         = (r_state == DONE);
  assign pass         = done && (r_mismatch_cnt == '0) && (r_checked_cnt != '0);
  assign err          = r_err;
  assign checked_cnt  = r_checked_cnt;
  assign mismatch_cnt = r_mismatch_cnt;
`ifdef PIPE_CHECKER_CAPTURE_EN
  assign first_exp    = r_first_exp;
  assign first_got    = r_first_got;
  assign first_idx    = r_first_idx;
`endif

endmodule

// File: tb/tb_pipe_result_checker.sv
// Directed bench for pipe_result_checker driving a three-register (a*b)&c pipeline model.
module tb_pipe_result_checker;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] c;
  logic [15:0] p;
  logic        fault;
  logic        busy;
  logic        done;
  logic        pass;
  logic        err;
  logic [15:0] checked_cnt;
  logic [15:0] mismatch_cnt;
`ifdef PIPE_CHECKER_CAPTURE_EN
  logic [15:0] first_exp;
  logic [15:0] first_got;
  logic [15:0] first_idx;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pipeline under test: three registers, optional fault tag forcing its output to 0.
  logic [31:0] m_prod;
  logic [15:0] m_p0, m_p1, m_p2;
  logic        m_f0, m_f1, m_f2;
  assign m_prod = {16'h0, a} * {16'h0, b};
  always @(posedge clk) begin
    m_p0 <= m_prod[15:0] & c;
    m_p1 <= m_p0;
    m_p2 <= m_p1;
    m_f0 <= fault;
    m_f1 <= m_f0;
    m_f2 <= m_f1;
  end
  assign p = m_f2 ? 16'h0000 : m_p2;

  pipe_result_checker #(
    .WIDTH     (16),
    .LATENCY   (3),
    .CNT_WIDTH (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .stop         (stop),
    .in_valid     (in_valid),
    .a            (a),
    .b            (b),
    .c            (c),
    .p            (p),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .err          (err),
    .checked_cnt  (checked_cnt),
    .mismatch_cnt (mismatch_cnt)
`ifdef PIPE_CHECKER_CAPTURE_EN
    ,
    .first_exp    (first_exp),
    .first_got    (first_got),
    .first_idx    (first_idx)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; in_valid = 1'b0;
    a = '0; b = '0; c = '0; fault = 1'b0;
    #2;
    check("rst_busy",     32'(busy), 32'd0);
    check("rst_done",     32'(done), 32'd0);
    check("rst_pass",     32'(pass), 32'd0);
    check("rst_err",      32'(err), 32'd0);
    check("rst_checked",  32'(checked_cnt), 32'd0);
    check("rst_mismatch", 32'(mismatch_cnt), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // single operand 3*5 & FFFF = 15
    start = 1'b1; tick(); start = 1'b0;
    check("t1_busy_run", 32'(busy), 32'd1);
    a = 16'd3; b = 16'd5; c = 16'hFFFF; in_valid = 1'b1; tick(); in_valid = 1'b0;
    stop = 1'b1; tick(); stop = 1'b0;
    tick();
    check("t1_pre_cmp_checked", 32'(checked_cnt), 32'd0);
    tick();
    check("t1_cmp_checked", 32'(checked_cnt), 32'd1);
    check("t1_cmp_not_done", 32'(done), 32'd0);
    tick();
    check("t1_done", 32'(done), 32'd1);
    check("t1_pass", 32'(pass), 32'd1);
    check("t1_mismatch", 32'(mismatch_cnt), 32'd0);
    check("t1_busy_idle", 32'(busy), 32'd0);

    // truncation: FFFF*2 = 1FFFE -> FFFE, twice
    start = 1'b1; tick(); start = 1'b0;
    check("t2_clear_checked", 32'(checked_cnt), 32'd0);
    a = 16'hFFFF; b = 16'd2; c = 16'hFFFF; in_valid = 1'b1; tick(); tick(); in_valid = 1'b0;
    stop = 1'b1; tick(); stop = 1'b0;
    tick(); tick(); tick();
    check("t2_done", 32'(done), 32'd1);
    check("t2_checked", 32'(checked_cnt), 32'd2);
    check("t2_mismatch", 32'(mismatch_cnt), 32'd0);
    check("t2_pass", 32'(pass), 32'd1);

    // ten back-to-back operands, fourth result forced to zero
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      a = 16'(i + 1); b = 16'd2; c = 16'h00FF; in_valid = 1'b1; fault = (i == 3);
      tick();
    end
    in_valid = 1'b0; fault = 1'b0;
    stop = 1'b1; tick(); stop = 1'b0;
    tick(); tick(); tick();
    check("t3_done", 32'(done), 32'd1);
    check("t3_err", 32'(err), 32'd1);
    check("t3_mismatch", 32'(mismatch_cnt), 32'd1);
    check("t3_checked", 32'(checked_cnt), 32'd10);
    check("t3_pass", 32'(pass), 32'd0);
`ifdef PIPE_CHECKER_CAPTURE_EN
    check("t3_first_idx", 32'(first_idx), 32'd3);
    check("t3_first_exp", 32'(first_exp), 32'd8);
    check("t3_first_got", 32'(first_got), 32'd0);
`endif

    // start+stop together in RUN: clear, stay in RUN, new operand 2*7=14 checked later
    start = 1'b1; tick(); start = 1'b0;
    check("t4_err_cleared", 32'(err), 32'd0);
    check("t4_checked_cleared", 32'(checked_cnt), 32'd0);
    a = 16'd3; b = 16'd5; c = 16'hFFFF; in_valid = 1'b1; tick();
    a = 16'd2; b = 16'd7; start = 1'b1; stop = 1'b1; tick();
    start = 1'b0; stop = 1'b0; in_valid = 1'b0;
    check("t4_busy", 32'(busy), 32'd1);
    check("t4_not_done", 32'(done), 32'd0);
    tick(); tick();
    check("t4_flushed", 32'(checked_cnt), 32'd0);
    tick();
    check("t4_new_checked", 32'(checked_cnt), 32'd1);
    check("t4_new_mismatch", 32'(mismatch_cnt), 32'd0);
    check("t4_still_run", 32'(busy), 32'd1);
    stop = 1'b1; tick(); stop = 1'b0;
    tick(); tick(); tick();
    check("t4_done", 32'(done), 32'd1);
    check("t4_pass", 32'(pass), 32'd1);

    // reset during drain discards everything
    start = 1'b1; tick(); start = 1'b0;
    a = 16'd1; b = 16'd1; c = 16'hFFFF; in_valid = 1'b1; tick(); tick();
    stop = 1'b1; tick(); stop = 1'b0; in_valid = 1'b0;
    tick();
    check("t5_pre_rst_checked", 32'(checked_cnt), 32'd1);
    check("t5_pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_done", 32'(done), 32'd0);
    check("t5_rst_checked", 32'(checked_cnt), 32'd0);
    check("t5_rst_pass", 32'(pass), 32'd0);
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    check("t5_post_checked", 32'(checked_cnt), 32'd0);
    check("t5_post_busy", 32'(busy), 32'd0);
    check("t5_post_done", 32'(done), 32'd0);

    // empty run: done after drain, nothing checked, no pass
    start = 1'b1; tick(); start = 1'b0;
    stop = 1'b1; tick(); stop = 1'b0;
    tick(); tick();
    check("t6_draining", 32'(busy), 32'd1);
    check("t6_not_done", 32'(done), 32'd0);
    tick();
    check("t6_done", 32'(done), 32'd1);
    check("t6_checked", 32'(checked_cnt), 32'd0);
    check("t6_pass", 32'(pass), 32'd0);
    stop = 1'b1; tick(); stop = 1'b0;
    check("t6_stop_ignored", 32'(done), 32'd1);
    a = 16'd3; b = 16'd5; c = 16'hFFFF; in_valid = 1'b1; tick(); tick(); in_valid = 1'b0;
    tick(); tick(); tick();
    check("t6_valid_ignored", 32'(checked_cnt), 32'd0);
    check("t6_still_done", 32'(done), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_result_checker.md
# pipe_result_checker

Self-checking consumer for the registered (a*b)&c DSP pipeline: it sits at the output end of the pipeline under test. It samples the operands presented to the pipeline and computes the expected result. It delays that result by the pipeline latency, compares it against the pipeline's output, and keeps running pass/mismatch statistics. It is used in hardware smoke tests of Lakeroad-mapped DSP netlists.

## Interface
- WIDTH, 16, operand/result width.
- LATENCY, 3, cycles from operand sample edge to result sample edge; legal 1..8.
- CNT_WIDTH, 16, counter width.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin (or restart) a run.
- stop  in  1  end operand issue; begin drain.
- in_valid  in  1  a/b/c are presented to the pipeline this cycle.
- a, b, c  in  WIDTH each  operands as driven to the pipeline.
- p  in  WIDTH  pipeline output.
- busy  out  1  state is RUN or DRAIN.
- done  out  1  state is DONE.
- pass  out  1  valid when done: mismatch_cnt==0 and checked_cnt!=0.
- err  out  1  sticky; set on first mismatch of a run.
- checked_cnt  out  CNT_WIDTH  results compared.
- mismatch_cnt  out  CNT_WIDTH  results that differed.

## Operation
- Expected value exp = ((a*b) mod 2^WIDTH) & c. The full 2·WIDTH product is truncated to the low WIDTH bits before the AND.
- Delay line has LATENCY entries of {v, exp}. Each cycle it shifts by one; the head entry is inserted as {in_valid & (state==RUN), exp}.
- Compare: when the tail entry has v=1, checked_cnt increments. If p != tail exp, mismatch_cnt increments and err sets.
- Both counters saturate at all-ones and never wrap.
- FSM:
  - IDLE: start goes to RUN and clears counters, err, and the delay line.
  - RUN: stop goes to DRAIN; start restarts (clears, stays in RUN).
  - DRAIN: inserts v=0 for LATENCY cycles, then goes to DONE. Compares continue during drain.
  - DONE: holds outputs; start goes to RUN with clear.
- Simultaneous start+stop: start wins; stop is ignored that cycle.
- stop in IDLE or DONE is ignored. in_valid outside RUN is ignored.
- Reset mid-run: all state is discarded.
- Reset values: busy=0, done=0, pass=0, err=0, both counters=0, state=IDLE, every delay-line v=0.

## Timing
- Operands sampled at edge t produce a compare against p sampled at edge t+LATENCY. For the three-register pipeline, LATENCY=3.
- Counters and err update at the compare edge and are visible the following cycle.
- Clear on start takes effect at the start edge. An in_valid in the same cycle as start is inserted after the clear.
- DRAIN lasts exactly LATENCY cycles. done asserts the cycle after the last drain compare edge.
- pass is combinational from done and the counters.
- Back-to-back in_valid every cycle is supported (II=1).

## Configuration
- PIPE_CHECKER_CAPTURE_EN defined: adds outputs first_exp (WIDTH), first_got (WIDTH), and first_idx (CNT_WIDTH).
  - These record the expected value, the actual value, and the checked_cnt index of the first mismatch of the run.
  - They reset to 0, clear on start, and are written only while err=0.
- Undefined: those ports and registers do not exist; all other behaviour is identical.

## Structure
- Package pipe_checker_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - function expected_result(a, b, c), parameterised by WIDTH;
  - constant MAX_LATENCY=8.
- Sub-module pipe_checker_delay: a parameterised LATENCY-deep shift register of {v, data} with synchronous clear and async active-low reset.

## Test plan
- Correct pipeline, a=3, b=5, c=16'hFFFF, single in_valid, then stop -> compare at edge +3 matches 15; done, pass=1, checked_cnt=1, mismatch_cnt=0.
- Overflow/truncation: a=16'hFFFF, b=2, c=16'hFFFF -> exp=16'hFFFE; p=16'hFFFE passes, p=16'h1FFFE[15:0] handled identically.
- Injected fault: p forced to 0 on the 4th of 10 back-to-back operands (a=i+1, b=2, c=16'h00FF) -> err=1, mismatch_cnt=1, checked_cnt=10, pass=0. With CAPTURE_EN: first_idx=3, first_exp=8.
- Simultaneous start and stop in RUN with in_valid=1 -> counters cleared, stays RUN, new operand checked LATENCY cycles later.
- rst_n pulsed low during DRAIN -> all outputs 0 immediately, state IDLE, no compare after reset release.
- No in_valid between start and stop -> done after LATENCY drain cycles, checked_cnt=0, pass=0.
